// File: rtl/coin_acceptor.sv
// Coin-slot front end: synchronises and debounces the Rs5/Rs10 sensors, buffers
// accepted coins and emits one single-cycle COIN code per coin while OPEN is low.
module coin_acceptor #(
    parameter int DEBOUNCE   = 4,
    parameter int FIFO_DEPTH = 4,
    parameter int GAP        = 1
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               sense5,
    input  logic                               sense10,
    input  logic                               open,
    output logic [1:0]                         coin,
    output logic                               reject,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]    pending,
    output logic                               full
);

    localparam int CW = $clog2(DEBOUNCE + 1);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = $clog2(FIFO_DEPTH + 1);
    localparam int GW = $clog2(GAP + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEND,
        ST_GAP
    } state_t;

    // Bit 0 is the Rs5 channel, bit 1 the Rs10 channel, so a single-channel
    // event vector is already the COIN code for that coin.
    logic [1:0] sense_vec;
    logic [1:0] event_vec;

    assign sense_vec = {sense10, sense5};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_chan
            logic          sync1_reg;
            logic          sync2_reg;
            logic          level_reg;
            logic          event_reg;
            logic [CW-1:0] cnt_reg;

            always_ff @(posedge clk) begin
                if (!reset) begin
                    sync1_reg <= 1'b0;
                    sync2_reg <= 1'b0;
                    level_reg <= 1'b0;
                    event_reg <= 1'b0;
                    cnt_reg   <= '0;
                end else begin
                    sync1_reg <= sense_vec[gi];
                    sync2_reg <= sync1_reg;
                    event_reg <= 1'b0;
                    if (sync2_reg == level_reg) begin
                        cnt_reg <= '0;
                    end else if (cnt_reg == CW'(DEBOUNCE - 1)) begin
                        // This sample is the DEBOUNCE-th consecutive differing one.
                        level_reg <= sync2_reg;
                        event_reg <= sync2_reg;
                        cnt_reg   <= '0;
                    end else begin
                        cnt_reg <= cnt_reg + CW'(1);
                    end
                end
            end

            assign event_vec[gi] = event_reg;
        end
    endgenerate

    logic [1:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [PW-1:0] count_reg;
    logic [PW-1:0] count_next;
    logic          full_reg;
    logic          reject_reg;
    logic          reject_next;
    logic [1:0]    coin_reg;
    logic          push;
    logic          pop;
    logic          one_event;

    state_t        state_reg;
    state_t        state_next;
    logic [GW-1:0] gap_cnt_reg;
    logic [GW-1:0] gap_cnt_next;

    always_comb begin
        one_event   = ^event_vec;
        pop         = (state_reg == ST_IDLE) && (count_reg != '0) && !open;
        push        = one_event && ((count_reg != PW'(FIFO_DEPTH)) || pop);
        reject_next = (&event_vec) || (one_event && !push);
        count_next  = count_reg;
        if (push && !pop) begin
            count_next = count_reg + PW'(1);
        end else if (pop && !push) begin
            count_next = count_reg - PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= event_vec;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            full_reg   <= 1'b0;
            reject_reg <= 1'b0;
            coin_reg   <= 2'b00;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            count_reg  <= count_next;
            full_reg   <= (count_next == PW'(FIFO_DEPTH));
            reject_reg <= reject_next;
            // Head is read on the pop edge so the code appears in the SEND cycle.
            coin_reg   <= pop ? mem[rd_ptr_reg] : 2'b00;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg   <= ST_IDLE;
            gap_cnt_reg <= '0;
        end else begin
            state_reg   <= state_next;
            gap_cnt_reg <= gap_cnt_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        gap_cnt_next = gap_cnt_reg;
        case (state_reg)
            ST_IDLE: begin
                if (pop) begin
                    state_next = ST_SEND;
                end
            end
            ST_SEND: begin
                state_next   = ST_GAP;
                gap_cnt_next = '0;
            end
            ST_GAP: begin
                if (gap_cnt_reg == GW'(GAP - 1)) begin
                    state_next   = ST_IDLE;
                    gap_cnt_next = '0;
                end else begin
                    gap_cnt_next = gap_cnt_reg + GW'(1);
                end
            end
            default: begin
                state_next   = ST_IDLE;
                gap_cnt_next = '0;
            end
        endcase
    end

    assign coin    = coin_reg;
    assign reject  = reject_reg;
    assign pending = count_reg;
    assign full    = full_reg;

endmodule

// File: tb/tb_coin_acceptor.sv
// Scenario bench for coin_acceptor: expected COIN codes are queued when a coin is
// driven and retired by a monitor as the DUT emits them.
module tb_coin_acceptor;

    localparam int DEBOUNCE   = 4;
    localparam int FIFO_DEPTH = 4;
    localparam int GAP        = 1;
    localparam int PW         = $clog2(FIFO_DEPTH + 1);

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          sense5 = 1'b0;
    logic          sense10 = 1'b0;
    logic          open_s = 1'b0;
    logic [1:0]    coin;
    logic          reject;
    logic [PW-1:0] pending;
    logic          full;

    int            errors = 0;
    int            checks = 0;
    int            cyc = 0;
    int            rej_seen = 0;
    int            last_pulse = -100;
    logic [1:0]    prev_coin = 2'b00;
    bit            mon_en = 1'b0;
    logic [1:0]    exp_q[$];
    int            pulse_times[$];

    coin_acceptor #(
        .DEBOUNCE  (DEBOUNCE),
        .FIFO_DEPTH(FIFO_DEPTH),
        .GAP       (GAP)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .sense5 (sense5),
        .sense10(sense10),
        .open   (open_s),
        .coin   (coin),
        .reject (reject),
        .pending(pending),
        .full   (full)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard monitor: every non-zero code must match the oldest expected coin.
    always @(negedge clk) begin
        if (mon_en) begin
            if (reject === 1'b1) rej_seen++;
            if (coin !== 2'b00) begin
                pulse_times.push_back(cyc);
                checks++;
                if (prev_coin !== 2'b00 || coin === 2'b11 || cyc - last_pulse < GAP + 2) begin
                    errors++;
                    $display("FAIL coin_shape: coin=%b prev=%b spacing=%0d, required single-cycle 01/10 spaced >= %0d",
                             coin, prev_coin, cyc - last_pulse, GAP + 2);
                end
                last_pulse = cyc;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL coin_unexpected: got coin=%b at cycle %0d, required no coin", coin, cyc);
                end else begin
                    logic [1:0] e;
                    e = exp_q.pop_front();
                    if (coin !== e) begin
                        errors++;
                        $display("FAIL coin_code: got %b, required %b", coin, e);
                    end
                end
            end
            prev_coin = coin;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One coin: sensor high for hold cycles, then low long enough to debounce the fall.
    task automatic send_coin(input int ch, input int hold);
        if (ch == 0) sense5 = 1'b1; else sense10 = 1'b1;
        tick(hold);
        sense5  = 1'b0;
        sense10 = 1'b0;
        tick(12);
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) tick(1);
        tick(4);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_drain: %0d coins still expected, required 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        tick(2);
        checks++;
        if (coin !== 2'b00 || reject !== 1'b0 || pending !== '0 || full !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: coin=%b reject=%b pending=%0d full=%b, required 00 0 0 0",
                     coin, reject, pending, full);
        end
        reset  = 1'b1;
        mon_en = 1'b1;
        tick(2);
    endtask

    task automatic test_latency();
        int s;
        pulse_times.delete();
        s = cyc;
        exp_q.push_back(2'b10);
        send_coin(1, 10);
        checks++;
        if (pulse_times.size() != 1 || pulse_times[0] - s != 8) begin
            errors++;
            $display("FAIL latency_rs10: pulses=%0d delay=%0d, required 1 pulse after 8 cycles",
                     pulse_times.size(), pulse_times.size() > 0 ? pulse_times[0] - s : -1);
        end
        pulse_times.delete();
        exp_q.push_back(2'b01);
        send_coin(0, 10);
        checks++;
        if (pulse_times.size() != 1) begin
            errors++;
            $display("FAIL latency_rs5: pulses=%0d, required 1", pulse_times.size());
        end
        wait_drain("latency");
    endtask

    task automatic test_glitch();
        int r0;
        int bad;
        r0  = rej_seen;
        bad = 0;
        pulse_times.delete();
        sense5 = 1'b1;
        tick(DEBOUNCE - 1);
        sense5 = 1'b0;
        for (int i = 0; i < 15; i++) begin
            tick(1);
            if (pending !== '0) bad++;
        end
        checks++;
        if (bad != 0 || pulse_times.size() != 0 || rej_seen != r0) begin
            errors++;
            $display("FAIL glitch: pending_nonzero_cycles=%0d pulses=%0d rejects=%0d, required 0 0 0",
                     bad, pulse_times.size(), rej_seen - r0);
        end
    endtask

    task automatic test_both();
        int r0;
        r0 = rej_seen;
        pulse_times.delete();
        sense5  = 1'b1;
        sense10 = 1'b1;
        tick(10);
        checks++;
        if (pending !== '0) begin
            errors++;
            $display("FAIL both_pending: pending=%0d, required 0", pending);
        end
        sense5  = 1'b0;
        sense10 = 1'b0;
        tick(12);
        checks++;
        if (rej_seen != r0 + 1 || pulse_times.size() != 0) begin
            errors++;
            $display("FAIL both_reject: rejects=%0d pulses=%0d, required 1 0", rej_seen - r0, pulse_times.size());
        end
    endtask

    task automatic test_full();
        int r0;
        int bad;
        open_s = 1'b1;
        for (int k = 0; k < FIFO_DEPTH; k++) begin
            exp_q.push_back(2'b10);
            send_coin(1, 10);
        end
        checks++;
        if (pending !== PW'(FIFO_DEPTH) || full !== 1'b1) begin
            errors++;
            $display("FAIL full_fill: pending=%0d full=%b, required %0d 1", pending, full, FIFO_DEPTH);
        end
        r0 = rej_seen;
        send_coin(1, 10);
        checks++;
        if (rej_seen != r0 + 1 || pending !== PW'(FIFO_DEPTH)) begin
            errors++;
            $display("FAIL full_overflow: rejects=%0d pending=%0d, required 1 %0d", rej_seen - r0, pending, FIFO_DEPTH);
        end
        pulse_times.delete();
        open_s = 1'b0;
        wait_drain("full");
        bad = 0;
        for (int i = 1; i < pulse_times.size(); i++)
            if (pulse_times[i] - pulse_times[i-1] != GAP + 2) bad++;
        checks++;
        if (pulse_times.size() != FIFO_DEPTH || bad != 0) begin
            errors++;
            $display("FAIL full_drain_spacing: pulses=%0d bad_gaps=%0d, required %0d 0", pulse_times.size(), bad, FIFO_DEPTH);
        end
        checks++;
        if (pending !== '0 || full !== 1'b0) begin
            errors++;
            $display("FAIL full_empty: pending=%0d full=%b, required 0 0", pending, full);
        end
    endtask

    task automatic test_push_pop();
        int r0;
        open_s = 1'b1;
        for (int k = 0; k < FIFO_DEPTH; k++) begin
            exp_q.push_back(2'b01);
            send_coin(0, 10);
        end
        r0 = rej_seen;
        exp_q.push_back(2'b10);
        sense10 = 1'b1;
        tick(DEBOUNCE + 2);
        open_s = 1'b0;
        tick(1);
        checks++;
        if (pending !== PW'(FIFO_DEPTH) || coin !== 2'b01) begin
            errors++;
            $display("FAIL pushpop_same_cycle: pending=%0d coin=%b, required %0d 01", pending, coin, FIFO_DEPTH);
        end
        tick(3);
        sense10 = 1'b0;
        wait_drain("pushpop");
        checks++;
        if (rej_seen != r0 || pending !== '0) begin
            errors++;
            $display("FAIL pushpop_reject: rejects=%0d pending=%0d, required 0 0", rej_seen - r0, pending);
        end
    endtask

    task automatic test_reset_mid();
        int k;
        open_s = 1'b1;
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(2'b10);
            send_coin(1, 10);
        end
        open_s = 1'b0;
        k = 0;
        while (coin !== 2'b10 && k < 50) begin
            tick(1);
            k++;
        end
        checks++;
        if (coin !== 2'b10) begin
            errors++;
            $display("FAIL rstmid_first: coin=%b after %0d cycles, required 10", coin, k);
        end
        tick(1);
        checks++;
        if (pending !== PW'(2) || coin !== 2'b00) begin
            errors++;
            $display("FAIL rstmid_gap: pending=%0d coin=%b, required 2 00", pending, coin);
        end
        reset = 1'b0;
        tick(1);
        checks++;
        if (coin !== 2'b00 || pending !== '0 || full !== 1'b0 || reject !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_clear: coin=%b pending=%0d full=%b reject=%b, required 00 0 0 0",
                     coin, pending, full, reject);
        end
        reset = 1'b1;
        exp_q.delete();
        pulse_times.delete();
        tick(20);
        checks++;
        if (pulse_times.size() != 0) begin
            errors++;
            $display("FAIL rstmid_stale: pulses=%0d after reset, required 0", pulse_times.size());
        end

        sense5 = 1'b1;
        tick(3);
        reset = 1'b0;
        tick(2);
        reset = 1'b1;
        exp_q.push_back(2'b01);
        tick(14);
        sense5 = 1'b0;
        tick(14);
        checks++;
        if (pulse_times.size() != 1) begin
            errors++;
            $display("FAIL held_through_reset: pulses=%0d, required 1", pulse_times.size());
        end
        wait_drain("held");
    endtask

    initial begin
        test_reset();
        test_latency();
        test_glitch();
        test_both();
        test_full();
        test_push_pop();
        test_reset_mid();
        tick(5);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
